synapse_stimulus_sequencer: RTL and testbench

//  Drives the neuron block for one picture: latches the input-axon spike vector and threshold bias,

---
 rtl/synapse_stimulus_sequencer_if.sv | 48 ++++
 rtl/synapse_stimulus_sequencer.sv | 158 +++++++++++++++
 tb/tb_synapse_stimulus_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/synapse_stimulus_sequencer_if.sv
// ============================================================================
// Module : synapse_stimulus_sequencer_if
// Brief  : Picture, synapse-matrix, neuron-block and result signals of the sequencer
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface synapse_stimulus_sequencer_if #(
  parameter int NUM_AXONS   = 256,
  parameter int AXON_W      = 8,
  parameter int NUM_NEURONS = 16
);
  logic                     pic_valid;
  logic                     pic_ready;
  logic [NUM_AXONS-1:0]     pic_axons;
  logic signed [15:0]       pic_bias;

  logic                     syn_req;
  logic [AXON_W-1:0]        syn_addr;
  logic                     syn_ack;
  logic [NUM_NEURONS-1:0]   syn_data;

  logic signed [15:0]       nrn_stimuli;
  logic [NUM_NEURONS-1:0]   nrn_connection;
  logic                     nrn_enable;
  logic                     nrn_picture_done;
  logic [NUM_NEURONS-1:0]   nrn_spike;

  logic [NUM_NEURONS-1:0]   result_spikes;
  logic                     result_valid;
  logic                     err_timeout;

  // master = sequencer side, slave = environment (host, NVM, neuron block)
  modport master (
    input  pic_valid, pic_axons, pic_bias, syn_ack, syn_data, nrn_spike,
    output pic_ready, syn_req, syn_addr, nrn_stimuli, nrn_connection, nrn_enable,
           nrn_picture_done, result_spikes, result_valid, err_timeout
  );

  modport slave (
    output pic_valid, pic_axons, pic_bias, syn_ack, syn_data, nrn_spike,
    input  pic_ready, syn_req, syn_addr, nrn_stimuli, nrn_connection, nrn_enable,
           nrn_picture_done, result_spikes, result_valid, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/synapse_stimulus_sequencer.sv
// ============================================================================
// Module : synapse_stimulus_sequencer
// Brief  : Sequences one picture: bias, per-axon synapse row fetch/apply, sample, clear
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module synapse_stimulus_sequencer #(
  parameter int                 NUM_AXONS   = 256,
  parameter int                 AXON_W      = 8,
  parameter int                 NUM_NEURONS = 16,
  parameter logic signed [15:0] STIM_VAL    = 16'sd1,
  parameter int                 ACK_TIMEOUT = 15
) (
  input  wire logic clk,
  input  wire logic rst,
  synapse_stimulus_sequencer_if.master bus
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AXON_W-1:0] LAST_PTR = AXON_W'(NUM_AXONS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BIAS   = 3'd1,
    S_SCAN   = 3'd2,
    S_REQ    = 3'd3,
    S_APPLY  = 3'd4,
    S_SETTLE = 3'd5,
    S_SAMPLE = 3'd6,
    S_CLEAR  = 3'd7
  } state_t;

  state_t                  state;
  logic [NUM_AXONS-1:0]    axons;
  logic [AXON_W-1:0]       ptr;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    syn_req;
  logic signed [15:0]      nrn_stimuli;
  logic [NUM_NEURONS-1:0]  nrn_connection;
  logic                    nrn_enable;
  logic                    nrn_picture_done;
  logic [NUM_NEURONS-1:0]  result_spikes;
  logic                    result_valid;
  logic                    err_timeout;

  // Outputs are registered on the transition into the state that owns them,
  // so each strobe is high exactly during its state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      axons            <= '0;
      ptr              <= '0;
      wait_cnt         <= '0;
      syn_req          <= 1'b0;
      nrn_stimuli      <= '0;
      nrn_connection   <= '0;
      nrn_enable       <= 1'b0;
      nrn_picture_done <= 1'b0;
      result_spikes    <= '0;
      result_valid     <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      nrn_stimuli      <= '0;
      nrn_connection   <= '0;
      nrn_enable       <= 1'b0;
      nrn_picture_done <= 1'b0;
      result_valid     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.pic_valid) begin
            axons          <= bus.pic_axons;
            ptr            <= '0;
            err_timeout    <= 1'b0;
            nrn_enable     <= 1'b1;
            nrn_connection <= '1;
            nrn_stimuli    <= bus.pic_bias;
            state          <= S_BIAS;
          end
        end

        S_BIAS: state <= S_SCAN;

        S_SCAN: begin
          if (axons[ptr]) begin
            syn_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= S_REQ;
          end else if (ptr == LAST_PTR) begin
            state <= S_SETTLE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end

        S_REQ: begin
          if (bus.syn_ack) begin
            syn_req <= 1'b0;
            state   <= S_APPLY;
            // An all-zero row connects to nothing, so it gets no apply strobe.
            if (bus.syn_data != '0) begin
              nrn_enable     <= 1'b1;
              nrn_connection <= bus.syn_data;
              nrn_stimuli    <= STIM_VAL;
            end
          end else if (wait_cnt == CNT_LAST) begin
            syn_req     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_APPLY;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_APPLY: begin
          if (ptr == LAST_PTR) begin
            state <= S_SETTLE;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= S_SCAN;
          end
        end

        S_SETTLE: begin
          result_spikes <= bus.nrn_spike;
          result_valid  <= 1'b1;
          state         <= S_SAMPLE;
        end

        S_SAMPLE: begin
          nrn_picture_done <= 1'b1;
          state            <= S_CLEAR;
        end

        S_CLEAR: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pic_ready        = (state == S_IDLE) && !rst;
  assign bus.syn_req          = syn_req;
  assign bus.syn_addr         = ptr;
  assign bus.nrn_stimuli      = nrn_stimuli;
  assign bus.nrn_connection   = nrn_connection;
  assign bus.nrn_enable       = nrn_enable;
  assign bus.nrn_picture_done = nrn_picture_done;
  assign bus.result_spikes    = result_spikes;
  assign bus.result_valid     = result_valid;
  assign bus.err_timeout      = err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_synapse_stimulus_sequencer.sv
// ============================================================================
// Module : tb_synapse_stimulus_sequencer
// Brief  : Scoreboard bench with NVM responder and neuron-block model attached
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_synapse_stimulus_sequencer;
  localparam int NA = 256;
  localparam int AW = 8;
  localparam int NN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  synapse_stimulus_sequencer_if #(.NUM_AXONS(NA), .AXON_W(AW), .NUM_NEURONS(NN)) bus ();

  synapse_stimulus_sequencer #(
    .NUM_AXONS(NA), .AXON_W(AW), .NUM_NEURONS(NN), .STIM_VAL(16'sd1), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] strobe(input logic [15:0] conn, input logic signed [15:0] stim);
    return {conn, stim};
  endfunction

  typedef struct { int addr; int len; } req_t;
  logic [31:0] exp_strobe[$];
  logic [15:0] exp_res[$];
  req_t        exp_req[$];

  // NVM synapse matrix responder
  logic [15:0] rows[NA];
  bit          noack[NA];
  int          rcnt = 0;
  always @(negedge clk) begin
    bus.syn_ack  = 1'b0;
    bus.syn_data = '0;
    if (bus.syn_req && !rst) begin
      rcnt++;
      if (!noack[bus.syn_addr] && rcnt == 2) begin
        bus.syn_ack  = 1'b1;
        bus.syn_data = rows[bus.syn_addr];
      end
    end else begin
      rcnt = 0;
    end
  end

  // Neuron block model: registered potentials, spike when potential >= 0
  logic signed [15:0] pot[NN];
  always @(posedge clk) begin
    for (int i = 0; i < NN; i++) begin
      if (rst || bus.nrn_picture_done) pot[i] <= 16'sd0;
      else if (bus.nrn_enable && bus.nrn_connection[i]) pot[i] <= pot[i] + bus.nrn_stimuli;
    end
  end
  always_comb begin
    bus.nrn_spike = '0;
    for (int i = 0; i < NN; i++) bus.nrn_spike[i] = (pot[i] >= 16'sd0);
  end

  // Monitor / scoreboard
  int   cyc = 0;
  int   done_count = 0, pic_starts = 0;
  int   done_cyc = 0, rv_cyc = 0, first_en_cyc = 0;
  bit   await_first = 1'b1;
  bit   req_active = 1'b0;
  int   req_len = 0;
  logic [AW-1:0] req_addr = '0;
  req_t cur_req;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      req_active  = 1'b0;
      await_first = 1'b1;
    end else begin
      if (bus.nrn_enable) begin
        if (await_first) begin
          await_first  = 1'b0;
          first_en_cyc = cyc;
          pic_starts++;
        end
        if (exp_strobe.size() == 0) check("unexpected_strobe", {bus.nrn_connection, bus.nrn_stimuli}, 32'h0);
        else check("strobe", {bus.nrn_connection, bus.nrn_stimuli}, exp_strobe.pop_front());
        check("done_with_enable", 32'(bus.nrn_picture_done), 32'h0);
      end else if (bus.nrn_connection != '0 || bus.nrn_stimuli != '0) begin
        check("nrn_bus_idle", {bus.nrn_connection, bus.nrn_stimuli}, 32'h0);
      end
      if (bus.result_valid) begin
        rv_cyc = cyc;
        if (exp_res.size() == 0) check("unexpected_result", 32'(bus.result_spikes), 32'hFFFF_FFFF);
        else check("result_spikes", 32'(bus.result_spikes), 32'(exp_res.pop_front()));
      end
      if (bus.nrn_picture_done) begin
        check("done_after_valid", 32'(cyc - rv_cyc), 32'd1);
        done_cyc    = cyc;
        await_first = 1'b1;
        done_count++;
      end
      if (bus.syn_req) begin
        if (!req_active) begin
          req_active = 1'b1;
          req_len    = 1;
          req_addr   = bus.syn_addr;
          if (exp_req.size() == 0) begin
            cur_req = '{addr: -1, len: 0};
            check("unexpected_req", 32'(bus.syn_addr), 32'hFFFF_FFFF);
          end else begin
            cur_req = exp_req.pop_front();
            check("syn_addr", 32'(bus.syn_addr), 32'(cur_req.addr));
          end
        end else begin
          req_len++;
          if (bus.syn_addr != req_addr) check("syn_addr_stable", 32'(bus.syn_addr), 32'(req_addr));
        end
      end else if (req_active) begin
        req_active = 1'b0;
        if (cur_req.len != 0) check("syn_req_len", 32'(req_len), 32'(cur_req.len));
      end
    end
  end

  task automatic start_pic(input logic [NA-1:0] ax, input logic signed [15:0] b);
    int t = 0;
    @(negedge clk);
    while (!bus.pic_ready && t < 2000) begin @(negedge clk); t++; end
    check("pic_ready_wait", 32'(bus.pic_ready), 32'h1);
    bus.pic_valid = 1'b1;
    bus.pic_axons = ax;
    bus.pic_bias  = b;
    @(negedge clk);
    bus.pic_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_count < target && t < 3000) begin @(negedge clk); #1; t++; end
    check("picture_done_seen", 32'(done_count >= target), 32'h1);
  endtask

  task automatic wait_starts(input int target);
    int t = 0;
    while (pic_starts < target && t < 3000) begin @(negedge clk); #1; t++; end
    check("picture_start_seen", 32'(pic_starts >= target), 32'h1);
  endtask

  task automatic check_drained();
    check("strobes_left", 32'(exp_strobe.size()), 32'h0);
    check("reqs_left", 32'(exp_req.size()), 32'h0);
    check("results_left", 32'(exp_res.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NA-1:0] ax;
    int d0, s0, done1;
    for (int i = 0; i < NA; i++) begin rows[i] = 16'h0; noack[i] = 1'b0; end
    rows[3] = 16'h0011; rows[200] = 16'h0001; rows[7] = 16'h0000;
    rows[9] = 16'h8000; rows[6] = 16'h0004; rows[10] = 16'h0F0F;
    bus.pic_valid = 1'b0; bus.pic_axons = '0; bus.pic_bias = '0;

    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_pic_ready", 32'(bus.pic_ready), 32'h0);
    check("rst_syn_req", 32'(bus.syn_req), 32'h0);
    check("rst_nrn_enable", 32'(bus.nrn_enable), 32'h0);
    check("rst_result", {15'h0, bus.result_valid, bus.result_spikes}, 32'h0);
    check("rst_err", 32'(bus.err_timeout), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.pic_ready), 32'h1);

    // Empty picture, bias -5
    exp_strobe.push_back(strobe(16'hFFFF, -16'sd5));
    exp_res.push_back(16'h0000);
    d0 = done_count;
    start_pic('0, -16'sd5);
    wait_done(d0 + 1);
    check("empty_latency", 32'(rv_cyc - first_en_cyc), 32'd258);
    check_drained();

    // Axons 3 and 200, bias -1
    ax = '0; ax[3] = 1'b1; ax[200] = 1'b1;
    exp_strobe.push_back(strobe(16'hFFFF, -16'sd1));
    exp_strobe.push_back(strobe(16'h0011, 16'sd1));
    exp_strobe.push_back(strobe(16'h0001, 16'sd1));
    exp_req.push_back('{addr: 3, len: 2});
    exp_req.push_back('{addr: 200, len: 2});
    exp_res.push_back(16'h0011);
    d0 = done_count;
    start_pic(ax, -16'sd1);
    wait_done(d0 + 1);
    check("err_clean", 32'(bus.err_timeout), 32'h0);
    check_drained();

    // Axon 7 with zero row, axon 9 with row 8000, bias 0
    ax = '0; ax[7] = 1'b1; ax[9] = 1'b1;
    exp_strobe.push_back(strobe(16'hFFFF, 16'sd0));
    exp_strobe.push_back(strobe(16'h8000, 16'sd1));
    exp_req.push_back('{addr: 7, len: 2});
    exp_req.push_back('{addr: 9, len: 2});
    exp_res.push_back(16'hFFFF);
    d0 = done_count;
    start_pic(ax, 16'sd0);
    wait_done(d0 + 1);
    check_drained();

    // Reset for two cycles while waiting on an ack
    noack[10] = 1'b1;
    ax = '0; ax[10] = 1'b1;
    exp_strobe.push_back(strobe(16'hFFFF, 16'sd0));
    exp_req.push_back('{addr: 10, len: 0});
    start_pic(ax, 16'sd0);
    begin
      int t = 0;
      while (!bus.syn_req && t < 400) begin @(negedge clk); t++; end
      check("req_before_rst", 32'(bus.syn_req), 32'h1);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_syn_req", 32'(bus.syn_req), 32'h0);
    check("midrst_nrn", {bus.nrn_connection, bus.nrn_stimuli}, 32'h0);
    check("midrst_strobes", {30'h0, bus.nrn_enable, bus.nrn_picture_done}, 32'h0);
    check("midrst_result", {15'h0, bus.result_valid, bus.result_spikes}, 32'h0);
    check("midrst_pic_ready", 32'(bus.pic_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(bus.pic_ready), 32'h1);
    noack[10] = 1'b0;
    check_drained();

    // Ack never comes for axon 5; axon 6 follows normally
    noack[5] = 1'b1;
    ax = '0; ax[5] = 1'b1; ax[6] = 1'b1;
    exp_strobe.push_back(strobe(16'hFFFF, -16'sd1));
    exp_strobe.push_back(strobe(16'h0004, 16'sd1));
    exp_req.push_back('{addr: 5, len: 15});
    exp_req.push_back('{addr: 6, len: 2});
    exp_res.push_back(16'h0004);
    d0 = done_count;
    start_pic(ax, -16'sd1);
    wait_done(d0 + 1);
    check("err_timeout_set", 32'(bus.err_timeout), 32'h1);
    noack[5] = 1'b0;
    check_drained();

    // pic_valid held high across two pictures
    for (int k = 0; k < 2; k++) begin
      exp_strobe.push_back(strobe(16'hFFFF, 16'sd3));
      exp_res.push_back(16'hFFFF);
    end
    d0 = done_count;
    s0 = pic_starts;
    @(negedge clk);
    bus.pic_axons = '0;
    bus.pic_bias  = 16'sd3;
    bus.pic_valid = 1'b1;
    wait_done(d0 + 1);
    done1 = done_cyc;
    wait_starts(s0 + 2);
    bus.pic_valid = 1'b0;
    check("back_to_back_gap", 32'(first_en_cyc - done1), 32'd2);
    check("err_cleared_on_accept", 32'(bus.err_timeout), 32'h0);
    wait_done(d0 + 2);
    check_drained();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
